// File: rtl/ysyx_22051013_lsu_seq.sv
// ysyx_22051013_lsu_seq: multi-cycle load/store unit with valid/ready bus and writeback ports
module ysyx_22051013_lsu_seq #(
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 64,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [3:0]          ls_ctl,
  input  logic [ADDR_W-1:0]   alu_res,
  input  logic [DATA_W-1:0]   store_data,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic                mem_req_we,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wstrb,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_resp_rdata,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   ls_data_o,
  output logic [1:0]          fault_o
);
  localparam int BEAT = DATA_W / 8;
  localparam int OW = $clog2(BEAT);
  localparam int SW = $clog2(DATA_W);
  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;
  state_t state_q, state_d;
  logic [3:0] ctl_q, ctl_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] sdata_q, sdata_d, res_q, res_d;
  logic [1:0] fault_q, fault_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0] sz;
  logic [OW-1:0] off;
  logic [BEAT-1:0] base, strb;
  logic [DATA_W-1:0] wshift, wdata, lane, tmp, ld_val;
  logic [SW-1:0] sh;
  logic is_req;
  function automatic logic [1:0] size_of(input logic [3:0] c);
    return c[3] ? (c[2:0] == 3'd4 ? 2'd3 : c[1:0] - 2'd1) : (c[2] ? {1'b1, c[0]} : c[1:0] - 2'd1);
  endfunction
  function automatic logic legal(input logic [3:0] c);
    return c[3] ? (c[2:0] != 3'd0 && !(DATA_W == 32 && (c[2:0] == 3'd4 || c[2:0] == 3'd7)))
                : (c == 4'd1 || c == 4'd2 || c == 4'd4 || (c == 4'd5 && DATA_W == 64));
  endfunction
  function automatic logic misaligned(input logic [3:0] c, input logic [2:0] a);
    return |(a & 3'((4'd1 << size_of(c)) - 4'd1));
  endfunction
  assign sz = size_of(ctl_q);
  assign off = addr_q[OW-1:0];
  assign base = ~({BEAT{1'b1}} << (4'd1 << sz));
  assign strb = ctl_q[3] ? '0 : base << off;
  assign wshift = sdata_q << {off, 3'b000};
  for (genvar i = 0; i < BEAT; i++) begin : g_lane
    assign wdata[8*i +: 8] = strb[i] ? wshift[8*i +: 8] : 8'd0;
  end
  assign lane = mem_resp_rdata >> {off, 3'b000};
  assign sh = SW'(DATA_W) - (SW'(8) << sz);
  assign tmp = lane << sh;
  assign ld_val = ctl_q[2:0] >= 3'd5 ? tmp >> sh : $unsigned($signed(tmp) >>> sh);
  assign is_req = state_q == REQ;
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign mem_req_valid = is_req;
  assign mem_req_addr = is_req ? {addr_q[ADDR_W-1:OW], {OW{1'b0}}} : '0;
  assign mem_req_we = is_req & ~ctl_q[3];
  assign mem_req_wdata = is_req ? wdata : '0;
  assign mem_req_wstrb = is_req ? strb : '0;
  assign ls_data_o = res_q;
  assign fault_o = fault_q;
  always_comb begin
    state_d = state_q;
    ctl_d = ctl_q;
    addr_d = addr_q;
    sdata_d = sdata_q;
    res_d = res_q;
    fault_d = fault_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (in_valid) begin
        ctl_d = ls_ctl;
        addr_d = alu_res;
        sdata_d = store_data;
        cnt_d = '0;
        res_d = ls_ctl == 4'd0 ? DATA_W'(alu_res) : '0;
        fault_d = ls_ctl == 4'd0 ? 2'b00 : !legal(ls_ctl) ? 2'b11 : misaligned(ls_ctl, alu_res[2:0]) ? 2'b01 : 2'b00;
        state_d = (ls_ctl == 4'd0 || fault_d != 2'b00) ? DONE : REQ;
      end
      REQ: begin
        cnt_d = '0;
        state_d = mem_req_ready ? RESP : REQ;
      end
      RESP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (mem_resp_valid) begin
          state_d = DONE;
          res_d = ctl_q[3] ? ld_val : '0;
          fault_d = 2'b00;
        end else if (TIMEOUT != 0 && cnt_d == CNT_W'(TIMEOUT)) begin
          state_d = DONE;
          res_d = '0;
          fault_d = 2'b10;
        end
      end
      default: state_d = out_ready ? IDLE : DONE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ctl_q <= '0;
      addr_q <= '0;
      sdata_q <= '0;
      res_q <= '0;
      fault_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      ctl_q <= ctl_d;
      addr_q <= addr_d;
      sdata_q <= sdata_d;
      res_q <= res_d;
      fault_q <= fault_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_ysyx_22051013_lsu_seq.sv
// tb_ysyx_22051013_lsu_seq: randomized and directed checks of the load/store unit against a byte-level model
module tb_ysyx_22051013_lsu_seq;
  localparam int TMO = 4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  logic in_valid, in_ready, mem_req_valid, mem_req_ready, mem_req_we, mem_resp_valid, out_valid, out_ready;
  logic [3:0] ls_ctl;
  logic [63:0] alu_res, store_data, mem_req_addr, mem_req_wdata, mem_resp_rdata, ls_data_o;
  logic [7:0] mem_req_wstrb;
  logic [1:0] fault_o;
  logic b_in_valid, b_in_ready, b_req_valid, b_req_ready, b_req_we, b_resp_valid, b_out_valid, b_out_ready;
  logic [3:0] b_ls_ctl;
  logic [31:0] b_alu_res, b_store_data, b_req_addr, b_req_wdata, b_resp_rdata, b_data;
  logic [3:0] b_req_wstrb;
  logic [1:0] b_fault;
  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;
  logic e_in_ready, e_req, e_we, e_out;
  logic [63:0] e_addr, e_wdata, e_data;
  logic [7:0] e_wstrb;
  logic [1:0] e_fault;
  ysyx_22051013_lsu_seq #(.DATA_W(64), .ADDR_W(64), .TIMEOUT(TMO), .CNT_W(8)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .ls_ctl(ls_ctl),
    .alu_res(alu_res), .store_data(store_data), .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr), .mem_req_we(mem_req_we),
    .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb), .mem_resp_valid(mem_resp_valid),
    .mem_resp_rdata(mem_resp_rdata), .out_valid(out_valid), .out_ready(out_ready),
    .ls_data_o(ls_data_o), .fault_o(fault_o));
  ysyx_22051013_lsu_seq #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(TMO), .CNT_W(8)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .ls_ctl(b_ls_ctl),
    .alu_res(b_alu_res), .store_data(b_store_data), .mem_req_valid(b_req_valid),
    .mem_req_ready(b_req_ready), .mem_req_addr(b_req_addr), .mem_req_we(b_req_we),
    .mem_req_wdata(b_req_wdata), .mem_req_wstrb(b_req_wstrb), .mem_resp_valid(b_resp_valid),
    .mem_resp_rdata(b_resp_rdata), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .ls_data_o(b_data), .fault_o(b_fault));
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int nbytes(input logic [3:0] c, input int dw);
    case (c)
      4'b1001, 4'b1101, 4'b0001: return 1;
      4'b1010, 4'b1110, 4'b0010: return 2;
      4'b1011, 4'b0100: return 4;
      4'b1111: return dw == 32 ? 0 : 4;
      4'b1100, 4'b0101: return dw == 64 ? 8 : 0;
      default: return 0;
    endcase
  endfunction
  function automatic logic [63:0] ld_model(input logic [3:0] c, input logic [63:0] a, input logic [63:0] rd, input int dw);
    int n = nbytes(c, dw);
    int off = int'(a % 64'(dw / 8));
    logic [63:0] m, v;
    m = n == 8 ? '1 : (64'd1 << (8 * n)) - 64'd1;
    v = (rd >> (8 * off)) & m;
    if (c[2:0] < 3'd5 && v[8*n-1]) v = v | ~m;
    return dw == 32 ? v & 64'hFFFF_FFFF : v;
  endfunction
  function automatic logic [63:0] st_strb(input logic [3:0] c, input logic [63:0] a);
    return ((64'd1 << nbytes(c, 64)) - 64'd1) << a[2:0];
  endfunction
  function automatic logic [63:0] st_wdata(input logic [3:0] c, input logic [63:0] a, input logic [63:0] sd);
    logic [63:0] w = '0;
    for (int i = 0; i < nbytes(c, 64); i++) w[8*(int'(a[2:0])+i) +: 8] = sd[8*i +: 8];
    return w;
  endfunction
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", 64'(in_ready), 64'(e_in_ready));
      chk("req_valid", 64'(mem_req_valid), 64'(e_req));
      chk("out_valid", 64'(out_valid), 64'(e_out));
      if (e_req) begin
        chk("req_addr", mem_req_addr, e_addr);
        chk("req_we", 64'(mem_req_we), 64'(e_we));
        chk("req_wdata", mem_req_wdata, e_wdata);
        chk("req_wstrb", 64'(mem_req_wstrb), 64'(e_wstrb));
      end
      if (e_out) begin
        chk("ls_data", ls_data_o, e_data);
        chk("fault", 64'(fault_o), 64'(e_fault));
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run_op(input logic [3:0] c, input logic [63:0] a, input logic [63:0] sd, input logic [63:0] rd,
                        input int rdly, input int pdly, input int odly);
    int n, k;
    bit got;
    logic [1:0] f;
    n = nbytes(c, 64);
    f = c == 4'd0 ? 2'd0 : n == 0 ? 2'd3 : (a % 64'(n)) != 0 ? 2'd1 : 2'd0;
    in_valid = 1'b1;
    ls_ctl = c;
    alu_res = a;
    store_data = sd;
    mem_resp_valid = 1'($urandom % 2);
    mem_req_ready = 1'($urandom % 2);
    e_in_ready = 1'b1;
    e_req = 1'b0;
    e_out = 1'b0;
    tick();
    in_valid = 1'b0;
    ls_ctl = 4'($urandom);
    alu_res = {$urandom, $urandom};
    store_data = {$urandom, $urandom};
    e_in_ready = 1'b0;
    if (c != 4'd0 && f == 2'd0) begin
      e_req = 1'b1;
      e_addr = a & ~64'h7;
      e_we = ~c[3];
      e_wstrb = c[3] ? 8'h00 : 8'(st_strb(c, a));
      e_wdata = c[3] ? 64'h0 : st_wdata(c, a, sd);
      for (int i = 0; i <= rdly; i++) begin
        mem_req_ready = i == rdly;
        mem_resp_valid = 1'($urandom % 2);
        mem_resp_rdata = {$urandom, $urandom};
        tick();
      end
      mem_req_ready = 1'b0;
      e_req = 1'b0;
      k = 1;
      got = 1'b0;
      while (!got && k <= TMO) begin
        got = k == pdly + 1;
        mem_resp_valid = got;
        mem_resp_rdata = got ? rd : {$urandom, $urandom};
        tick();
        k++;
      end
      e_data = got && c[3] ? ld_model(c, a, rd, 64) : 64'h0;
      e_fault = got ? 2'd0 : 2'd2;
    end else begin
      e_data = c == 4'd0 ? a : 64'h0;
      e_fault = f;
    end
    e_out = 1'b1;
    for (int i = 0; i <= odly; i++) begin
      out_ready = i == odly;
      mem_resp_valid = 1'($urandom % 2);
      mem_req_ready = 1'($urandom % 2);
      tick();
    end
    out_ready = 1'b0;
    mem_resp_valid = 1'b0;
    mem_req_ready = 1'b0;
    e_out = 1'b0;
    e_in_ready = 1'b1;
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit exceeded");
    $fatal(1);
  end
  initial begin
    logic [3:0] codes [12] = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};
    logic [3:0] c;
    logic [63:0] a;
    {in_valid, mem_req_ready, mem_resp_valid, out_ready} = '0;
    ls_ctl = '0;
    alu_res = '0;
    store_data = '0;
    mem_resp_rdata = '0;
    {b_in_valid, b_req_ready, b_resp_valid, b_out_ready} = '0;
    b_ls_ctl = '0;
    b_alu_res = '0;
    b_store_data = '0;
    b_resp_rdata = '0;
    #1 rst = 1'b1;
    #2;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_req_valid", 64'(mem_req_valid), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_data", ls_data_o, 64'd0);
    chk("rst_fault", 64'(fault_o), 64'd0);
    chk("rst_req_addr", mem_req_addr, 64'd0);
    chk("rst_b_in_ready", 64'(b_in_ready), 64'd1);
    chk("rst_b_data", 64'(b_data), 64'd0);
    #9 rst = 1'b0;
    tick();
    e_in_ready = 1'b1;
    e_req = 1'b0;
    e_out = 1'b0;
    chk_en = 1'b1;
    chk("pin_lb", ld_model(4'b1001, 64'h8000_0003, 64'h1122_3344_8566_7788, 64), 64'hFFFF_FFFF_FFFF_FF85);
    chk("pin_lwu", ld_model(4'b1111, 64'h1004, 64'h8000_0001_DEAD_BEEF, 64), 64'h0000_0000_8000_0001);
    chk("pin_sh_wdata", st_wdata(4'b0010, 64'h1006, 64'hABCD), 64'hABCD_0000_0000_0000);
    chk("pin_sh_strb", st_strb(4'b0010, 64'h1006), 64'hC0);
    run_op(4'b1001, 64'h8000_0003, 64'h0, 64'h1122_3344_8566_7788, 0, 0, 0);
    run_op(4'b0010, 64'h1006, 64'hABCD, 64'h0, 4, 0, 0);
    run_op(4'b1011, 64'h1002, 64'h0, 64'h0, 0, 0, 0);
    run_op(4'b1111, 64'h1004, 64'h0, 64'h8000_0001_DEAD_BEEF, 0, 0, 0);
    run_op(4'b1100, 64'h2000, 64'h0, 64'h0123_4567_89AB_CDEF, 0, 9, 0);
    run_op(4'b1100, 64'h2000, 64'h0, 64'h0123_4567_89AB_CDEF, 0, 3, 0);
    run_op(4'b1110, 64'h2002, 64'h0, 64'h0000_0000_8001_0000, 1, 2, 5);
    run_op(4'b0000, 64'hDEAD_BEEF_0000_1234, 64'h0, 64'h0, 0, 0, 2);
    run_op(4'b0011, 64'h3000, 64'h0, 64'h0, 0, 0, 0);
    run_op(4'b0101, 64'h3000, 64'h1122_3344_5566_7788, 64'h0, 2, 1, 1);
    for (int t = 0; t < 250; t++) begin
      c = ($urandom % 5 != 0) ? codes[$urandom % 12] : 4'($urandom);
      a = {$urandom, $urandom};
      if ($urandom % 2 == 1) a[2:0] = 3'd0;
      run_op(c, a, {$urandom, $urandom}, {$urandom, $urandom}, int'($urandom % 4), int'($urandom % 7), int'($urandom % 4));
      for (int i = 0; i < int'($urandom % 2); i++) tick();
    end
    chk_en = 1'b0;
    in_valid = 1'b1;
    ls_ctl = 4'b1100;
    alu_res = 64'h3000;
    tick();
    in_valid = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    chk("resp_in_ready", 64'(in_ready), 64'd0);
    chk("resp_req_valid", 64'(mem_req_valid), 64'd0);
    #2 rst = 1'b1;
    #1;
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_req_valid", 64'(mem_req_valid), 64'd0);
    chk("arst_data", ls_data_o, 64'd0);
    chk("arst_fault", 64'(fault_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk_en = 1'b1;
    run_op(4'b1010, 64'h4002, 64'h0, 64'h0000_0000_FFFF_0000, 0, 0, 0);
    b_in_valid = 1'b1;
    b_ls_ctl = 4'b0101;
    b_alu_res = 32'h1000;
    tick();
    b_in_valid = 1'b0;
    chk("b_sd_valid", 64'(b_out_valid), 64'd1);
    chk("b_sd_fault", 64'(b_fault), 64'd3);
    chk("b_sd_noreq", 64'(b_req_valid), 64'd0);
    b_out_ready = 1'b1;
    tick();
    b_out_ready = 1'b0;
    b_in_valid = 1'b1;
    b_ls_ctl = 4'b1111;
    tick();
    b_in_valid = 1'b0;
    chk("b_lwu_fault", 64'(b_fault), 64'd3);
    b_out_ready = 1'b1;
    tick();
    b_out_ready = 1'b0;
    b_in_valid = 1'b1;
    b_ls_ctl = 4'b0000;
    b_alu_res = 32'h1234;
    tick();
    b_in_valid = 1'b0;
    chk("b_pass_valid", 64'(b_out_valid), 64'd1);
    chk("b_pass_data", 64'(b_data), 64'h1234);
    chk("b_pass_noreq", 64'(b_req_valid), 64'd0);
    b_out_ready = 1'b1;
    tick();
    b_out_ready = 1'b0;
    b_in_valid = 1'b1;
    b_ls_ctl = 4'b1010;
    b_alu_res = 32'h1006;
    tick();
    b_in_valid = 1'b0;
    chk("b_lh_addr", 64'(b_req_addr), 64'h1004);
    chk("b_lh_strb", 64'(b_req_wstrb), 64'h0);
    b_req_ready = 1'b1;
    tick();
    b_req_ready = 1'b0;
    b_resp_valid = 1'b1;
    b_resp_rdata = 32'h8001_0000;
    tick();
    b_resp_valid = 1'b0;
    chk("b_lh_data", 64'(b_data), 64'hFFFF_8001);
    chk("b_lh_fault", 64'(b_fault), 64'd0);
    b_out_ready = 1'b1;
    tick();
    b_out_ready = 1'b0;
    b_in_valid = 1'b1;
    b_ls_ctl = 4'b0001;
    b_alu_res = 32'h1003;
    b_store_data = 32'h1234_56AB;
    tick();
    b_in_valid = 1'b0;
    chk("b_sb_wdata", 64'(b_req_wdata), 64'hAB00_0000);
    chk("b_sb_strb", 64'(b_req_wstrb), 64'h8);
    chk("b_sb_we", 64'(b_req_we), 64'd1);
    b_req_ready = 1'b1;
    tick();
    b_req_ready = 1'b0;
    b_resp_valid = 1'b1;
    tick();
    b_resp_valid = 1'b0;
    chk("b_sb_data", 64'(b_data), 64'h0);
    b_out_ready = 1'b1;
    tick();
    b_out_ready = 1'b0;
    tick();
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ysyx_22051013_lsu_seq.md
Name: ysyx_22051013_lsu_seq

Overview:
Multi-cycle load/store unit for the MEM stage. It replaces the combinational DPI access with a valid/ready request/response memory port. It takes one ls_ctl-encoded operation per transaction from EX, issues one beat-aligned bus access, extracts and extends load data, and hands the result to WB through a valid/ready handshake. It also reports misaligned-access and bus-timeout faults.

Parameters:
DATA_W, 64, bus and register width; legal values are 32 or 64. BEAT = DATA_W/8 bytes.
ADDR_W, 64, address width.
TIMEOUT, 255, maximum number of cycles to wait for mem_resp_valid; 0 disables the timeout.
CNT_W, 8, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
in_valid  in  1  EX presents an operation
in_ready  out  1  unit accepts an operation
ls_ctl  in  4  bit3=1 load: 001 lb, 010 lh, 011 lw, 100 ld, 101 lbu, 110 lhu, 111 lwu; bit3=0 store: 0001 sb, 0010 sh, 0100 sw, 0101 sd; 0000 no memory access
alu_res  in  ADDR_W  effective address, or the pass-through value when ls_ctl=0000
store_data  in  DATA_W  rs2 value
mem_req_valid  out  1  bus request
mem_req_ready  in  1  bus accepts the request
mem_req_addr  out  ADDR_W  address aligned down to BEAT
mem_req_we  out  1  1 = write
mem_req_wdata  out  DATA_W  lane-shifted store data
mem_req_wstrb  out  BEAT  byte mask
mem_resp_valid  in  1  response beat; exactly one per request, for both read and write
mem_resp_rdata  in  DATA_W  read beat
out_valid  out  1  result available
out_ready  in  1  WB accepts the result
ls_data_o  out  DATA_W  load result; alu_res pass-through for ls_ctl=0000; 0 for stores
fault_o  out  2  00 none, 01 misaligned, 10 bus timeout, 11 illegal ls_ctl; valid only while out_valid=1

Behaviour:
- The FSM has four states: IDLE, REQ, RESP, DONE.
- Reset (async): state = IDLE; in_ready = 1; mem_req_valid = 0; out_valid = 0; ls_data_o = 0; fault_o = 00; mem_req_* = 0; all captured registers = 0.
- IDLE: in_ready = 1. On in_valid, the unit captures ls_ctl, alu_res and store_data, then:
  - ls_ctl=0000 -> DONE, fault 00, ls_data_o = alu_res[DATA_W-1:0].
  - Illegal code -> DONE, fault 11. Illegal means: an undefined code; or, when DATA_W=32, any of ld, lwu, sd.
  - Misaligned -> DONE, fault 01, no bus request. Misaligned means: half with addr[0]≠0; word with addr[1:0]≠0; double with addr[2:0]≠0.
  - Otherwise -> REQ.
- REQ: mem_req_valid = 1, and all mem_req_* fields are held stable until mem_req_ready. The handshake completes in the same cycle both are high, then -> RESP. The timeout counter clears when REQ is entered.
  - wstrb: sb = 1<<off; sh = 3<<off; sw = 0xF<<off; sd = 0xFF, where off = addr mod BEAT.
  - wdata: store operand replicated or shifted into its lane by off*8; bytes outside the strobe are 0.
  - Loads drive wstrb = 0.
- RESP: the counter increments each cycle without mem_resp_valid.
  - On mem_resp_valid -> DONE. For a load, select the lane at off, then sign- or zero-extend to DATA_W. For a store, ls_data_o = 0.
  - If the counter reaches TIMEOUT (TIMEOUT≠0) -> DONE, fault 10, ls_data_o = 0.
  - A response arriving in the same cycle the counter reaches TIMEOUT wins: the result is normal.
- DONE: out_valid = 1; ls_data_o and fault_o are held stable until out_ready. Handshake -> IDLE. in_ready stays 0 outside IDLE, so there is no overlap.
- Latency: minimum 3 cycles from in_valid to out_valid for a bus access (IDLE→REQ→RESP→DONE with zero-wait ready and response). ls_ctl=0000 and faulted operations take 1 cycle.
- mem_resp_valid outside RESP is ignored. A timed-out transaction's late response is dropped.
- Reset asserted mid-transaction aborts immediately to IDLE. The bus side must tolerate the abandoned request.

Test Plan:
1. DATA_W=64, lb at addr 0x8000_0003; bus returns 0x1122_3344_8566_7788 -> mem_req_addr 0x8000_0000, wstrb 0x00; ls_data_o 0xFFFF_FFFF_FFFF_FF85, fault 00, out_valid on cycle 3.
2. sh of store_data 0xABCD at addr 0x1006, mem_req_ready delayed 4 cycles -> request fields stable throughout; wdata 0xABCD_0000_0000_0000, wstrb 0xC0, ls_data_o 0.
3. lw at addr 0x1002 -> no mem_req_valid, out_valid next cycle with fault 01; lwu at 0x1004 with rdata 0x8000_0001_xxxx_xxxx -> ls_data_o 0x0000_0000_8000_0001.
4. TIMEOUT=4, ld with no response -> fault 10 after 4 RESP cycles, ls_data_o 0. A response injected on the 4th cycle instead yields fault 00 with correct data.
5. out_ready held low 5 cycles in DONE -> out_valid, ls_data_o and fault_o unchanged, in_ready 0. rst pulsed during RESP -> all outputs 0 and state IDLE asynchronously.
6. DATA_W=32: sd -> fault 11; ls_ctl=0000 with alu_res 0x1234 -> ls_data_o 0x1234 next cycle, no bus activity.
